bounce_gen: RTL
===============

# bounce_gen

Synthesises a realistic mechanical-contact bounce waveform from a clean level request. Each change of `level_in` produces a pseudo-random burst of glitches on `btn_out` before the output settles. The block is the stimulus end of the button path: it drives the pulse-counter board's debouncer input in on-chip self-test, and the debounce bench uses it as the button model.

## Interface
- `PRESC_W`, 8: prescaler width. One bounce tick occurs every 2^PRESC_W clocks.
- `SEED`, 16'hACE1: LFSR reset value. Must be non-zero.
- `SETTLE_TICKS`, 8: length of the final stable phase, in ticks. Range 1..16.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `level_in` in 1: requested clean level. Synchronous to `clk`.
- `bounce_en` in 1: 1 produces a bouncing transition; 0 produces a clean transition.
- `btn_out` out 1: emulated contact output, registered.
- `busy` out 1: high while a transition sequence is in progress.
- `settled` out 1: one-cycle pulse when `btn_out` reaches its final level.

## Operation
- **Prescaler:** PRESC_W-bit free-running up-counter. `tick` = (count == 0).
- **LFSR:** 16-bit Galois LFSR, taps 16'hB400, advances every clock.
  - `nb` = lfsr[2:0]: number of bounces, 0..7.
  - `ph` = lfsr[5:3]: phase length minus 1, giving 1..8 ticks.
- **Registers:**
  - `target`: latched destination level.
  - `bounces`: 3-bit remaining-bounce counter.
  - `phase`: 4-bit tick down-counter.
- **States:** IDLE, ON_TARGET, OFF_TARGET.
- **IDLE:**
  - Entry condition: `level_in != btn_out`.
  - If `bounce_en` = 0:
    - `btn_out <= level_in` and `settled` pulses in the same cycle.
    - State stays IDLE.
  - If `bounce_en` = 1:
    - `target <= level_in`, `btn_out <= level_in`, `bounces <= nb`.
    - `phase <= (nb == 0) ? SETTLE_TICKS-1 : ph`.
    - Next state ON_TARGET; `busy <= 1`.
- **ON_TARGET, on tick:**
  - If `phase != 0`: `phase--`.
  - Else if `bounces == 0`: go to IDLE, `busy <= 0`, `settled` pulses.
  - Else: `btn_out <= ~target`, `phase <= ph`, go to OFF_TARGET.
- **OFF_TARGET, on tick:**
  - If `phase != 0`: `phase--`.
  - Else:
    - `btn_out <= target`, `bounces--`.
    - `phase <= (bounces-1 == 0) ? SETTLE_TICKS-1 : ph`.
    - Go to ON_TARGET.
- **No tick:** all counters hold.
- **`level_in` while busy:** ignored. After the return to IDLE, a mismatch starts a new sequence the following cycle.
- **`bounce_en` while busy:** changes are ignored; it is sampled only in IDLE.
- **Glitch count:** each sequence produces exactly `nb` off-target glitches, i.e. 2·`nb`+1 edges on `btn_out`.

## Timing
- **Reset values:** `btn_out` = 0, `busy` = 0, `settled` = 0, state IDLE, prescaler 0, `lfsr` = SEED, `bounces`/`phase`/`target` = 0.
- **First edge:** `btn_out` changes one clock after `level_in` first differs from it, in both modes.
- **`busy`:** rises with the first edge. Falls in the same cycle that `settled` pulses.
- **Phase duration:** each phase lasts (`phase`+1) ticks. The first tick may arrive anywhere from 0 to 2^PRESC_W−1 clocks after entry, so each duration is ±1 tick.
- **Final stable phase:** SETTLE_TICKS ticks (±1 tick).
- **Worst-case sequence:** 7·8 + 7·8 + SETTLE_TICKS + 1 ticks.
- **Reset mid-sequence:** the block returns to IDLE immediately. `btn_out` goes to 0, and no `settled` pulse is produced.
- **Coincident tick on entry:** a tick in the same cycle as IDLE→ON_TARGET is not counted toward the new phase.

## Structure
- **`bounce_pkg`:**
  - state enum (IDLE/ON_TARGET/OFF_TARGET);
  - LFSR tap constant 16'hB400;
  - default SEED and SETTLE_TICKS.
- **Sub-module `bounce_lfsr`:** 16-bit Galois LFSR with SEED parameter and asynchronous reset. Output is the full state.
- **Top level:** FSM, prescaler and counters.

## Test plan
- **Reset:** assert `reset` mid-burst with `btn_out` = 1 → `btn_out`/`busy`/`settled` = 0 within the same cycle. After release, no activity until `level_in` ≠ 0.
- **Clean mode:** `bounce_en` = 0, `level_in` 0→1 → `btn_out` = 1 one clock later, `settled` = 1 for exactly one cycle, `busy` stays 0.
- **Bouncing rise:** `bounce_en` = 1, PRESC_W = 4, `level_in` 0→1 → odd edge count ≤ 15 on `btn_out`; final level 1 held ≥ SETTLE_TICKS·16 − 16 clocks before `settled`. Scoreboard predicts exact edges from the LFSR model.
- **Mid-sequence change:** toggle `level_in` 1→0 while `busy` → no reaction until `settled`; a new sequence starts the cycle after IDLE, ending at `btn_out` = 0.
- **Loop-back through the debouncer:** 100 random transitions from `bounce_gen` into the debouncer → debounced output equals `level_in` after every `settled`, with no extra debounced edges.
- **Seed determinism:** two resets with the same SEED and identical stimulus → cycle-identical `btn_out` traces.

Source files
------------

// File: rtl/bounce_pkg.sv
// Shared definitions for the contact-bounce generator: FSM states,
// LFSR polynomial and default parameters.
package bounce_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ON_TARGET  = 2'd1,
    OFF_TARGET = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS            = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED         = 16'hACE1;
  localparam int          DEFAULT_SETTLE_TICKS = 8;

  // Right-shifting Galois step: feedback taken from bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit Galois LFSR, free-running; the full state is exposed so the
// caller can carve out whichever random fields it needs.
module bounce_lfsr
  import bounce_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SEED;
    else       state <= lfsr_next(state);
  end

endmodule

// File: rtl/bounce_gen.sv
// Mechanical contact bounce emulator: each change of level_in yields a
// pseudo-random burst of glitches on btn_out before it settles.
module bounce_gen
  import bounce_pkg::*;
#(
  parameter int          PRESC_W      = 8,
  parameter logic [15:0] SEED         = DEFAULT_SEED,
  parameter int          SETTLE_TICKS = DEFAULT_SETTLE_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  input  logic bounce_en,
  output logic btn_out,
  output logic busy,
  output logic settled
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_TICKS - 1);

  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic [15:0]        lfsr;
  logic [2:0]         nb;
  logic [3:0]         ph;
  logic               lfsr_unused;

  state_t     state;
  logic       target;
  logic [2:0] bounces;
  logic [3:0] phase;

  bounce_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .state(lfsr)
  );

  assign tick        = (presc == '0);
  assign nb          = lfsr[2:0];
  assign ph          = {1'b0, lfsr[5:3]};
  assign lfsr_unused = ^lfsr[15:6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc   <= '0;
      state   <= IDLE;
      target  <= 1'b0;
      bounces <= '0;
      phase   <= '0;
      btn_out <= 1'b0;
      busy    <= 1'b0;
      settled <= 1'b0;
    end else begin
      presc   <= presc + PRESC_W'(1);
      settled <= 1'b0;
      case (state)
        IDLE: begin
          if (level_in != btn_out) begin
            btn_out <= level_in;
            if (!bounce_en) begin
              settled <= 1'b1;
            end else begin
              target  <= level_in;
              bounces <= nb;
              phase   <= (nb == '0) ? SETTLE_LAST : ph;
              state   <= ON_TARGET;
              busy    <= 1'b1;
            end
          end
        end
        ON_TARGET: begin
          if (tick) begin
            if (phase != '0) begin
              phase <= phase - 4'd1;
            end else if (bounces == '0) begin
              state   <= IDLE;
              busy    <= 1'b0;
              settled <= 1'b1;
            end else begin
              btn_out <= ~target;
              phase   <= ph;
              state   <= OFF_TARGET;
            end
          end
        end
        OFF_TARGET: begin
          if (tick) begin
            if (phase != '0) begin
              phase <= phase - 4'd1;
            end else begin
              btn_out <= target;
              bounces <= bounces - 3'd1;
              // Last glitch just ended: the next on-target phase is the settle phase.
              phase   <= (bounces == 3'd1) ? SETTLE_LAST : ph;
              state   <= ON_TARGET;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
